// File: rtl/cbus_sram_responder_pkg.sv
// rtl/cbus_sram_responder_pkg.sv - shared cache-bus access types (request/response, mlen/msize/burst)
package cbus_sram_responder_pkg;

  localparam int CBUS_ADDR_W = 32;
  localparam int CBUS_DATA_W = 32;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

  // Beats per transaction minus one
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
    MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
    MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
    MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
  } mlen_e;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    msize_e                 size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    mlen_e                  len;
    burst_e                 burst;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_burst_addr.sv
// rtl/cbus_burst_addr.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module cbus_burst_addr
  import cbus_sram_responder_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic [AW+1:0] cur_addr,
  input  mlen_e         len,
  input  burst_e        burst,
  output logic [AW+1:0] next_addr
);

  logic [AW+1:0] incr_addr;
  logic [AW+1:0] wrap_mask;

  // INCR wraps naturally at the array size; WRAP only lets the bits inside the
  // (len+1)*4-byte window change, which is {len, 2'b11} for power-of-two lengths
  always_comb begin
    incr_addr = cur_addr + (AW+2)'(4);
    wrap_mask = (AW+2)'({len, 2'b11});
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/cbus_sram_responder.sv
// rtl/cbus_sram_responder.sv - cache-bus responder backed by a byte-writable word array
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int WORDS   = 4096,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       busy
);

  localparam int AW = $clog2(WORDS);
  localparam int CW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [AW+1:0] cur_addr;
  logic [AW+1:0] next_addr;
  mlen_e         len_q;
  burst_e        burst_q;
  logic          wr_q;
  logic [3:0]    beat;

  logic [31:0]   mem [WORDS];

  logic          in_burst;
  logic          last_beat;
  logic          beat_en;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign in_burst  = (state == BURST);
  assign last_beat = (beat == len_q);
  // A beat only commits while the initiator still holds valid
  assign beat_en   = in_burst && creq.valid;
  assign rd_word   = mem[cur_addr[AW+1:2]];
  assign busy      = (state != IDLE);

  // size and the out-of-range/sub-word address bits have no effect here
  assign unused_bits = ^{creq.size, creq.addr[CBUS_ADDR_W-1:AW+2], creq.addr[1:0]};

  cbus_burst_addr #(.AW(AW)) u_burst_addr (
    .cur_addr  (cur_addr),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Response beat: all-zero outside BURST, read data only on read beats
  always_comb begin
    cresp       = '0;
    cresp.ready = in_burst;
    cresp.last  = in_burst && last_beat;
    cresp.data  = (in_burst && !wr_q) ? rd_word : '0;
  end

  // Transaction FSM: accept, count out the latency, then stream len+1 beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_addr <= '0;
      len_q    <= MLEN1;
      burst_q  <= BURST_FIXED;
      wr_q     <= 1'b0;
      beat     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (creq.valid) begin
            cur_addr <= {creq.addr[AW+1:2], 2'b00};
            len_q    <= creq.len;
            burst_q  <= creq.burst;
            wr_q     <= creq.is_write;
            beat     <= '0;
            cnt      <= CW'(LATENCY);
            state    <= (LATENCY == 0) ? BURST : WAIT;
          end
        end
        WAIT: begin
          if (!creq.valid) begin
            state <= IDLE;
          end else if ((cnt == CW'(0)) || (cnt == CW'(1))) begin
            state <= BURST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BURST: begin
          if (!creq.valid || last_beat) begin
            state <= IDLE;
          end else begin
            beat     <= beat + 1'b1;
            cur_addr <= next_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane writes on the edge that ends a write beat; contents survive reset
  always_ff @(posedge clk) begin
    if (beat_en && wr_q) begin
      for (int i = 0; i < CBUS_STRB_W; i++) begin
        if (creq.strobe[i]) begin
          mem[cur_addr[AW+1:2]][8*i +: 8] <= creq.data[8*i +: 8];
        end
      end
    end
  end

endmodule
